fifo_wr_arbiter: RTL and testbench

Round-robin arbiter sharing the write port of the dual-clock FIFO (`yibififo`) among `NUM_REQ` producers in the write clock domain. Each producer presents a valid/ready stream. The arbiter grants one producer at a time, optionally for a locked burst, and drives `wr_en`/`din` of the FIFO while honouring `full`. It sits directly in front of the FIFO write side; the read side is untouched.

---
 rtl/fifo_wr_arbiter_if.sv | 44 ++++
 rtl/fifo_wr_arbiter.sv | 166 ++++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter_if
// Bundles the requester streams and the FIFO write-side signals of the
// round-robin write arbiter.
//
// Signals:
//   req_valid  [NUM_REQ]          requester i has a beat on its data slice
//   req_data   [NUM_REQ*DATA_W]   requester i data at [i*DATA_W +: DATA_W]
//   req_ready  [NUM_REQ]          one-hot/zero, beat from i accepted this cycle
//   fifo_full                     FIFO full flag
//   fifo_wr_en                    FIFO write enable
//   fifo_din   [DATA_W]           FIFO write data
//   grant_id   [GID_W]            current or last granted requester
//   busy                          arbiter is transferring
//
// Modports:
//   master  arbiter side (drives ready / FIFO write / status)
//   slave   environment side (requesters and FIFO)
// ---------------------------------------------------------------------------
interface fifo_wr_arbiter_if #(
    parameter int DATA_W  = 16,
    parameter int NUM_REQ = 4
);
    localparam int GID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      fifo_full;
    logic                      fifo_wr_en;
    logic [DATA_W-1:0]         fifo_din;
    logic [GID_W-1:0]          grant_id;
    logic                      busy;

    modport master (
        input  req_valid, req_data, fifo_full,
        output req_ready, fifo_wr_en, fifo_din, grant_id, busy
    );

    modport slave (
        output req_valid, req_data, fifo_full,
        input  req_ready, fifo_wr_en, fifo_din, grant_id, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
// Round-robin arbiter sharing the write port of the dual-clock FIFO among
// NUM_REQ valid/ready producers in the write clock domain. One requester is
// granted at a time; wr_en is never raised while the FIFO is full.
//
// Ports:
//   wr_clk    write-domain clock
//   wr_rst_n  asynchronous active-low reset
//   arb       fifo_wr_arbiter_if.master (requester streams + FIFO write side)
//
// Build option:
//   FIFO_ARB_LOCK_EN  defined   -> a grant is held for up to MAX_BURST beats
//                     undefined -> grant released after every beat
//                                  (beat counter not built)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no grant active, waiting for any req_valid
// XFER  | grant_id owns the FIFO write port, beats flow when not full
// ---------------------------------------------------------------------------
module fifo_wr_arbiter #(
    parameter int DATA_W    = 16,
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 8
) (
    input  logic                  wr_clk,
    input  logic                  wr_rst_n,
    fifo_wr_arbiter_if.master     arb
);
    localparam int GID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [GID_W-1:0]   grant_q, grant_d;
    logic [GID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [GID_W-1:0]   grant_inc;
    logic               valid_g;
    logic               beat;
    logic               last_beat;
    logic               drop;
    logic               rel;
    logic               load;

    logic [GID_W-1:0]   scan_ptr;
    logic [NUM_REQ-1:0] scan_mask;
    logic [NUM_REQ-1:0] avail;
    logic               win_found;
    logic [GID_W-1:0]   win_idx;
    logic [NUM_REQ-1:0] ready;

    assign grant_inc = (int'(grant_q) == NUM_REQ - 1) ? '0 : grant_q + 1'b1;
    assign valid_g   = arb.req_valid[grant_q];
    assign beat      = (state_q == XFER) && valid_g && !arb.fifo_full;
    assign drop      = (state_q == XFER) && !valid_g;
    assign rel       = drop || (beat && last_beat);

    // In XFER the scan is only consumed on release, so it always starts just
    // past the current grant; the owner is excluded only when it dropped valid.
    assign scan_ptr = (state_q == XFER) ? grant_inc : rr_ptr_q;

    always_comb begin
        scan_mask = '0;
        if (drop) begin
            scan_mask[grant_q] = 1'b1;
        end
    end

    assign avail = arb.req_valid & ~scan_mask;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!win_found && avail[(int'(scan_ptr) + k) % NUM_REQ]) begin
                win_found = 1'b1;
                win_idx   = GID_W'((int'(scan_ptr) + k) % NUM_REQ);
            end
        end
    end

`ifdef FIFO_ARB_LOCK_EN
    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

    assign last_beat = (int'(beat_cnt_q) == MAX_BURST - 1);

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (load) begin
            beat_cnt_d = '0;
        end else if (beat && !rel) begin
            beat_cnt_d = beat_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            beat_cnt_q <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
        end
    end
`else
    assign last_beat = 1'b1;
`endif

    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        load     = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = XFER;
                    grant_d = win_idx;
                    load    = 1'b1;
                end
            end
            XFER: begin
                if (rel) begin
                    rr_ptr_d = grant_inc;
                    if (win_found) begin
                        grant_d = win_idx;
                        load    = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready = '0;
        if (beat) begin
            ready[grant_q] = 1'b1;
        end
    end

    assign arb.req_ready  = ready;
    assign arb.fifo_wr_en = beat;
    assign arb.fifo_din   = arb.req_data[int'(grant_q)*DATA_W +: DATA_W];
    assign arb.grant_id   = grant_q;
    assign arb.busy       = (state_q == XFER);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;
    localparam int DATA_W    = 16;
    localparam int NUM_REQ   = 4;
    localparam int MAX_BURST = 8;
`ifdef FIFO_ARB_LOCK_EN
    localparam int BURST = MAX_BURST;
`else
    localparam int BURST = 1;
`endif

    logic wr_clk   = 1'b0;
    logic wr_rst_n = 1'b0;
    always #5 wr_clk = ~wr_clk;

    fifo_wr_arbiter_if #(.DATA_W(DATA_W), .NUM_REQ(NUM_REQ)) bus ();

    fifo_wr_arbiter #(
        .DATA_W(DATA_W),
        .NUM_REQ(NUM_REQ),
        .MAX_BURST(MAX_BURST)
    ) dut (
        .wr_clk(wr_clk),
        .wr_rst_n(wr_rst_n),
        .arb(bus)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0] valid;
        logic       full;
        logic       wr_en;
        logic [3:0] ready;
        int         grant;
        logic       busy;
    } vec_t;

    vec_t tbl [13];

    // reference model: owner of the write port, beats taken in this grant,
    // and where the next round-robin search starts
    logic m_busy;
    int   m_owner, m_taken, m_next, w;
    int   sent [NUM_REQ];

    function automatic int first_from(input logic [3:0] v, input int start, input int skip);
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = (start + k) % NUM_REQ;
            if (v[idx] && idx != skip) return idx;
        end
        return -1;
    endfunction

    initial begin
        logic [3:0] v;
        logic       f;
        logic       exp_beat;
        logic [3:0] exp_ready;
        logic [15:0] exp_din;

        // ---------------- reset with every requester valid ----------------
        bus.req_valid = 4'hF;
        bus.fifo_full = 1'b0;
        bus.req_data  = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
        @(negedge wr_clk);
        @(negedge wr_clk);
        check("rst wr_en", bus.fifo_wr_en, 1'b0);
        check("rst ready", bus.req_ready, 4'b0000);
        check("rst busy", bus.busy, 1'b0);
        check("rst grant", bus.grant_id, 0);
        check("rst din", bus.fifo_din, 16'hA000);
        @(posedge wr_clk); #1;
        bus.req_valid = 4'h0;
        wr_rst_n = 1'b1;

        // ---------------- table of directed vectors ----------------
        tbl[0]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 0, 1'b0};
        tbl[1]  = '{4'b0010, 1'b0, 1'b0, 4'b0000, 0, 1'b0};
        tbl[2]  = '{4'b0010, 1'b0, 1'b1, 4'b0010, 1, 1'b1};
        tbl[3]  = '{4'b0010, 1'b1, 1'b0, 4'b0000, 1, 1'b1};
        tbl[4]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1, 1'b1};
        tbl[5]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1, 1'b0};
        tbl[6]  = '{4'b1001, 1'b0, 1'b0, 4'b0000, 1, 1'b0};
        tbl[7]  = '{4'b1000, 1'b0, 1'b1, 4'b1000, 3, 1'b1};
        tbl[8]  = '{4'b1001, 1'b1, 1'b0, 4'b0000, 3, 1'b1};
        tbl[9]  = '{4'b0001, 1'b1, 1'b0, 4'b0000, 3, 1'b1};
        tbl[10] = '{4'b0001, 1'b0, 1'b1, 4'b0001, 0, 1'b1};
        tbl[11] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 0, 1'b1};
        tbl[12] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 0, 1'b0};

        for (int r = 0; r < 13; r++) begin
            bus.req_valid = tbl[r].valid;
            bus.fifo_full = tbl[r].full;
            @(negedge wr_clk);
            check($sformatf("tbl%0d wr_en", r), bus.fifo_wr_en, tbl[r].wr_en);
            check($sformatf("tbl%0d ready", r), bus.req_ready, tbl[r].ready);
            check($sformatf("tbl%0d grant", r), bus.grant_id, tbl[r].grant);
            check($sformatf("tbl%0d busy", r), bus.busy, tbl[r].busy);
            check($sformatf("tbl%0d din", r), bus.fifo_din, 32'hA000 + tbl[r].grant);
            @(posedge wr_clk); #1;
        end

        // ---------------- all four valid continuously ----------------
        wr_rst_n = 1'b0;
        bus.req_valid = 4'hF;
        bus.fifo_full = 1'b0;
        @(posedge wr_clk); #1;
        wr_rst_n = 1'b1;
        @(negedge wr_clk);
        check("all4 bubble wr_en", bus.fifo_wr_en, 1'b0);
        check("all4 bubble busy", bus.busy, 1'b0);
        @(posedge wr_clk); #1;
        for (int i = 0; i < 32; i++) begin
            int g;
            g = (i / BURST) % NUM_REQ;
            @(negedge wr_clk);
            check($sformatf("all4 beat%0d wr_en", i), bus.fifo_wr_en, 1'b1);
            check($sformatf("all4 beat%0d grant", i), bus.grant_id, g);
            check($sformatf("all4 beat%0d ready", i), bus.req_ready, 32'd1 << g);
            @(posedge wr_clk); #1;
        end

        // asynchronous reset in the middle of a burst, checked before any edge
        #2;
        wr_rst_n = 1'b0;
        #1;
        check("async rst wr_en", bus.fifo_wr_en, 1'b0);
        check("async rst ready", bus.req_ready, 4'b0000);
        check("async rst busy", bus.busy, 1'b0);
        bus.req_valid = 4'h0;
        @(posedge wr_clk); #1;
        wr_rst_n = 1'b1;

        // ---------------- randomized run against the model ----------------
        m_busy  = 1'b0;
        m_owner = 0;
        m_taken = 0;
        m_next  = 0;
        for (int r = 0; r < NUM_REQ; r++) sent[r] = 0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int r = 0; r < NUM_REQ; r++) begin
                v[r] = ($urandom_range(0, 7) != 0);
                bus.req_data[r*DATA_W +: DATA_W] = {4'(r), 12'(sent[r])};
            end
            f = ($urandom_range(0, 4) == 0);
            bus.req_valid = v;
            bus.fifo_full = f;
            @(negedge wr_clk);

            exp_beat  = m_busy && v[m_owner] && !f;
            exp_ready = exp_beat ? (4'b0001 << m_owner) : 4'b0000;
            exp_din   = {4'(m_owner), 12'(sent[m_owner])};
            check($sformatf("rnd%0d wr_en", cyc), bus.fifo_wr_en, exp_beat);
            check($sformatf("rnd%0d ready", cyc), bus.req_ready, exp_ready);
            check($sformatf("rnd%0d busy", cyc), bus.busy, m_busy);
            check($sformatf("rnd%0d grant", cyc), bus.grant_id, m_owner);
            check($sformatf("rnd%0d din", cyc), bus.fifo_din, exp_din);

            if (exp_beat) sent[m_owner]++;
            if (!m_busy) begin
                w = first_from(v, m_next, -1);
                if (w >= 0) begin
                    m_busy  = 1'b1;
                    m_owner = w;
                    m_taken = 0;
                end
            end else if (!v[m_owner]) begin
                m_next = (m_owner + 1) % NUM_REQ;
                w = first_from(v, m_next, m_owner);
                if (w >= 0) begin
                    m_owner = w;
                    m_taken = 0;
                end else begin
                    m_busy = 1'b0;
                end
            end else if (!f) begin
                m_taken++;
                if (m_taken == BURST) begin
                    m_next = (m_owner + 1) % NUM_REQ;
                    w = first_from(v, m_next, -1);
                    if (w >= 0) begin
                        m_owner = w;
                        m_taken = 0;
                    end else begin
                        m_busy = 1'b0;
                    end
                end
            end
            @(posedge wr_clk); #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
